// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex driver for common-anode seven-segment banks with dead time, blanking and lamp test.
// Define SEVSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  BI_,
  input  logic                  LT_,
  output logic [6:0]            SevenS,
  output logic [DIGITS-1:0]     AN
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow;
  logic [3:0]            digit;
  logic [6:0]            segDec;
  logic [6:0]            segNext;
  logic [DIGITS-1:0]     anNext;
  logic                  inDead;
  logic                  blankLz;

  if (DEAD > 0) begin : gDead
    assign inDead = (pcnt < PW'(DEAD));
  end else begin : gNoDead
    assign inDead = 1'b0;
  end

  always_comb begin
    digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) digit = shadow[4*i +: 4];
    end
  end

  always_comb begin
    case (digit)
      4'h0: segDec = 7'b1000000;
      4'h1: segDec = 7'b1111001;
      4'h2: segDec = 7'b0100100;
      4'h3: segDec = 7'b0110000;
      4'h4: segDec = 7'b0011001;
      4'h5: segDec = 7'b0010010;
      4'h6: segDec = 7'b0000010;
      4'h7: segDec = 7'b1111000;
      4'h8: segDec = 7'b0000000;
      4'h9: segDec = 7'b0011000;
      4'hA: segDec = 7'b0001000;
      4'hB: segDec = 7'b0000011;
      4'hC: segDec = 7'b1000110;
      4'hD: segDec = 7'b0100001;
      4'hE: segDec = 7'b0000110;
      default: segDec = 7'b0001110;
    endcase
  end

`ifdef SEVSEG_LZB_EN
  // lzMask[i] is set when every digit from the top down to i is zero
  logic [DIGITS:0] lzMask;

  always_comb begin
    lzMask         = '0;
    lzMask[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lzMask[i] = lzMask[i+1] && (shadow[4*i +: 4] == 4'h0);
    end
    blankLz = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (idx == IW'(i)) blankLz = lzMask[i];
    end
  end
`else
  assign blankLz = 1'b0;
`endif

  always_comb begin
    anNext  = '1;
    segNext = 7'b1111111;
    if (BI_ && !inDead) begin
      anNext = ~(DIGITS'(1) << idx);
      if (!LT_)
        segNext = 7'b0000000;
      else if (blankLz)
        segNext = 7'b1111111;
      else
        segNext = segDec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt   <= '0;
      idx    <= '0;
      shadow <= '0;
      AN     <= '1;
      SevenS <= 7'b1111111;
    end else begin
      if (load) shadow <= value;
      if (pcnt == PW'(PRESCALE - 1)) begin
        pcnt <= '0;
        idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
      AN     <= anNext;
      SevenS <= segNext;
    end
  end

endmodule
